// File: rtl/button_event_ctrl.sv
// Push-button front end: per-channel sync + debounce, press/release/long-press detection,
// and round-robin serialization of events into a show-ahead valid/ready FIFO.
module button_event_ctrl #(
    parameter int unsigned N_BUTTONS    = 4,
    parameter int unsigned BOUNCE_TICKS = 10,
    parameter int unsigned LONG_TICKS   = 1000,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_BUTTONS-1:0]         buttons_raw,
    output logic [N_BUTTONS-1:0]         levels,
    output logic                         event_valid,
    input  logic                         event_ready,
    output logic [$clog2(N_BUTTONS)-1:0] event_id,
    output logic [1:0]                   event_type,
    output logic                         overflow,
    input  logic                         overflow_clr
);
    localparam int unsigned ID_W  = $clog2(N_BUTTONS);
    localparam int unsigned BC_W  = $clog2(BOUNCE_TICKS);
    localparam int unsigned HC_W  = $clog2(LONG_TICKS + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_RELEASE = 2'b10;
    localparam logic [1:0] EV_LONG    = 2'b11;

    typedef enum logic [1:0] {S_0, S_MAYBE_1, S_1, S_MAYBE_0} state_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      kind;
    } event_t;

    logic [N_BUTTONS-1:0] sync1_q, sync2_q;
    state_t               state_q [N_BUTTONS];
    state_t               state_d [N_BUTTONS];
    logic [BC_W-1:0]      bcnt_q [N_BUTTONS];
    logic [BC_W-1:0]      bcnt_d [N_BUTTONS];
    logic [HC_W-1:0]      hcnt_q [N_BUTTONS];
    logic [HC_W-1:0]      hcnt_d [N_BUTTONS];
    logic [N_BUTTONS-1:0] levels_d;
    logic [N_BUTTONS-1:0] new_ev;
    logic [1:0]           new_kind [N_BUTTONS];

    logic [N_BUTTONS-1:0] slot_q, slot_d;
    logic [1:0]           slot_kind_q [N_BUTTONS];
    logic [1:0]           slot_kind_d [N_BUTTONS];
    logic                 overflow_d;

    logic                 grant;
    logic [ID_W-1:0]      grant_id, cand, ptr_q;
    event_t               push_ev;

    event_t               mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    event_t               head_q, head_d;
    logic                 valid_q, pop;

    // Debounce FSM and hold counter per channel; produces at most one event per channel per cycle.
    always_comb begin
        for (int i = 0; i < int'(N_BUTTONS); i++) begin
            state_d[i]  = state_q[i];
            bcnt_d[i]   = bcnt_q[i];
            hcnt_d[i]   = hcnt_q[i];
            new_ev[i]   = 1'b0;
            new_kind[i] = EV_PRESS;
            case (state_q[i])
                S_0: begin
                    if (sync2_q[i]) begin
                        state_d[i] = S_MAYBE_1;
                        bcnt_d[i]  = '0;
                    end
                end
                S_MAYBE_1: begin
                    bcnt_d[i] = bcnt_q[i] + BC_W'(1);
                    if (bcnt_q[i] == BC_W'(BOUNCE_TICKS - 1)) begin
                        bcnt_d[i] = '0;
                        if (sync2_q[i]) begin
                            state_d[i]  = S_1;
                            new_ev[i]   = 1'b1;
                            new_kind[i] = EV_PRESS;
                        end else begin
                            state_d[i] = S_0;
                        end
                    end
                end
                S_1: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = S_MAYBE_0;
                        bcnt_d[i]  = '0;
                    end
                end
                S_MAYBE_0: begin
                    bcnt_d[i] = bcnt_q[i] + BC_W'(1);
                    if (bcnt_q[i] == BC_W'(BOUNCE_TICKS - 1)) begin
                        bcnt_d[i] = '0;
                        if (!sync2_q[i]) begin
                            state_d[i]  = S_0;
                            new_ev[i]   = 1'b1;
                            new_kind[i] = EV_RELEASE;
                        end else begin
                            state_d[i] = S_1;
                        end
                    end
                end
                default: state_d[i] = S_0;
            endcase
            levels_d[i] = (state_d[i] == S_1) || (state_d[i] == S_MAYBE_0);

            // A release commit on the same edge suppresses counting, so LONG never collides with RELEASE.
            if (new_ev[i] && (new_kind[i] == EV_PRESS)) begin
                hcnt_d[i] = '0;
            end else if (levels[i] && levels_d[i] && (hcnt_q[i] != HC_W'(LONG_TICKS))) begin
                hcnt_d[i] = hcnt_q[i] + HC_W'(1);
                if (hcnt_d[i] == HC_W'(LONG_TICKS)) begin
                    new_ev[i]   = 1'b1;
                    new_kind[i] = EV_LONG;
                end
            end
        end
    end

    // Round-robin grant starting after the last granted channel.
    always_comb begin
        grant    = 1'b0;
        grant_id = ptr_q;
        cand     = ptr_q;
        for (int k = 1; k <= int'(N_BUTTONS); k++) begin
            cand = ID_W'((int'(ptr_q) + k) % int'(N_BUTTONS));
            if (!grant && slot_q[cand] && (count_q < CNT_W'(FIFO_DEPTH))) begin
                grant    = 1'b1;
                grant_id = cand;
            end
        end
    end

    assign push_ev = {grant_id, slot_kind_q[grant_id]};

    // Pending slots: a granted slot may accept a new event on the same edge.
    always_comb begin
        slot_d      = slot_q;
        slot_kind_d = slot_kind_q;
        overflow_d  = overflow_clr ? 1'b0 : overflow;
        if (grant) slot_d[grant_id] = 1'b0;
        for (int i = 0; i < int'(N_BUTTONS); i++) begin
            if (new_ev[i]) begin
                if (slot_d[i]) begin
                    overflow_d = 1'b1;
                end else begin
                    slot_d[i]      = 1'b1;
                    slot_kind_d[i] = new_kind[i];
                end
            end
        end
    end

    // FIFO bookkeeping; the head register is refilled so outputs come straight from flops.
    always_comb begin
        pop     = valid_q & event_ready;
        count_d = count_q + CNT_W'(grant) - CNT_W'(pop);
        rd_d    = rd_q + PTR_W'(pop);
        wr_d    = wr_q + PTR_W'(grant);
        head_d  = head_q;
        if ((count_q - CNT_W'(pop)) == '0) begin
            if (grant) head_d = push_ev;
        end else begin
            head_d = mem_q[rd_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            levels   <= '0;
            slot_q   <= '0;
            overflow <= 1'b0;
            ptr_q    <= ID_W'(N_BUTTONS - 1);
            rd_q     <= '0;
            wr_q     <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
            for (int i = 0; i < int'(N_BUTTONS); i++) begin
                state_q[i]     <= S_0;
                bcnt_q[i]      <= '0;
                hcnt_q[i]      <= '0;
                slot_kind_q[i] <= '0;
            end
        end else begin
            sync1_q  <= buttons_raw;
            sync2_q  <= sync1_q;
            levels   <= levels_d;
            slot_q   <= slot_d;
            overflow <= overflow_d;
            if (grant) ptr_q <= grant_id;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            count_q  <= count_d;
            valid_q  <= (count_d != '0);
            head_q   <= head_d;
            for (int i = 0; i < int'(N_BUTTONS); i++) begin
                state_q[i]     <= state_d[i];
                bcnt_q[i]      <= bcnt_d[i];
                hcnt_q[i]      <= hcnt_d[i];
                slot_kind_q[i] <= slot_kind_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant) mem_q[wr_q] <= push_ev;
    end

    assign event_valid = valid_q;
    assign event_id    = head_q.id;
    assign event_type  = head_q.kind;

endmodule
